// File: rtl/axi_slave.sv
// AXI3-style slave with a 2**MEM_ADDR_WIDTH x 32-bit memory, INCR bursts, independent write and read FSMs.
// Latency: AW->W one cycle, last W->B one cycle, AR->first R one cycle (R data is a combinational memory read).
// Backpressure: B and R outputs hold until bready/rready; AW/AR/W accepted only in their own FSM states.
// Optional feature: define AXI_SLAVE_WLAST_CHECK_EN to return SLVERR when i_wlast disagrees with the beat count.
module axi_slave #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [31:0]             i_awaddr,
    input  logic [AXI_ID_WIDTH-1:0] i_awid,
    input  logic [3:0]              i_awlen,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [31:0]             i_wdata,
    input  logic [AXI_ID_WIDTH-1:0] i_wid,
    input  logic [3:0]              i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [AXI_ID_WIDTH-1:0] o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [31:0]             i_araddr,
    input  logic [AXI_ID_WIDTH-1:0] i_arid,
    input  logic [3:0]              i_arlen,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [31:0]             o_rdata,
    output logic [AXI_ID_WIDTH-1:0] o_rid,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [31:0] mem_q [DEPTH];

    wstate_t                   wstate_q;
    logic                      awready_q, wready_q, bvalid_q;
    logic [AXI_ID_WIDTH-1:0]   bid_q;
    logic [1:0]                bresp_q;
    logic [MEM_ADDR_WIDTH-1:0] widx_q;
    logic [3:0]                wlen_q, wcnt_q;
    logic                      w_fire;
    logic                      werr_d;

    rstate_t                   rstate_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [AXI_ID_WIDTH-1:0]   rid_q;
    logic [MEM_ADDR_WIDTH-1:0] ridx_q;
    logic [3:0]                rlen_q, rcnt_q;

    // Address bits outside the word index and the W-channel ID carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{i_wid, i_wlast, i_awaddr[31:MEM_ADDR_WIDTH+2], i_awaddr[1:0],
                             i_araddr[31:MEM_ADDR_WIDTH+2], i_araddr[1:0]};

    assign w_fire = wready_q & i_wvalid;

`ifdef AXI_SLAVE_WLAST_CHECK_EN
    logic werr_q;
    // Sticky error: any beat whose wlast disagrees with "this is beat len".
    assign werr_d = werr_q | (i_wlast != (wcnt_q == wlen_q));
`else
    assign werr_d = 1'b0;
`endif

    // Write channel FSM: capture AW, accept len+1 beats, then hold B until accepted.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
            werr_q    <= 1'b0;
`endif
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (i_awvalid && awready_q) begin
                        widx_q    <= i_awaddr[MEM_ADDR_WIDTH+1:2];
                        wlen_q    <= i_awlen;
                        bid_q     <= i_awid;
                        wcnt_q    <= '0;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
                        werr_q    <= 1'b0;
`endif
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        widx_q <= widx_q + 1'b1;
                        wcnt_q <= wcnt_q + 4'd1;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
                        werr_q <= werr_d;
`endif
                        // Beat count alone terminates the burst; wlast only feeds the error flag.
                        if (wcnt_q == wlen_q) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= werr_d ? 2'b10 : 2'b00;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (i_bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Memory write port: byte lanes enabled by wstrb; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) mem_q[widx_q][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Read channel FSM: capture AR, present len+1 beats, advance on each rready.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (i_arvalid && arready_q) begin
                        ridx_q    <= i_araddr[MEM_ADDR_WIDTH+1:2];
                        rlen_q    <= i_arlen;
                        rid_q     <= i_arid;
                        rcnt_q    <= '0;
                        rlast_q   <= (i_arlen == 4'd0);
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            ridx_q  <= ridx_q + 1'b1;
                            rcnt_q  <= rcnt_q + 4'd1;
                            rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign o_awready = awready_q;
    assign o_wready  = wready_q;
    assign o_bvalid  = bvalid_q;
    assign o_bid     = bid_q;
    assign o_bresp   = bresp_q;
    assign o_arready = arready_q;
    assign o_rvalid  = rvalid_q;
    assign o_rlast   = rlast_q;
    assign o_rid     = rid_q;
    assign o_rresp   = 2'b00;
    // Combinational read so a write committed last cycle is already visible.
    assign o_rdata   = rvalid_q ? mem_q[ridx_q] : 32'h0;
endmodule

// File: tb/tb_axi_slave.sv
// Scoreboard bench for axi_slave: stimulus pushes expected B/R responses, a negedge monitor checks them.
// Reference memory is a plain array updated with strobe rules when each write is issued.
// Directed scenarios first, then randomized write/read pairs with random backpressure.
module tb_axi_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  awid = '0, awlen = '0, wid = '0, wstrb = '0, arid = '0, arlen = '0;
    logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid;
    logic [3:0]  o_bid, o_rid;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata;

    axi_slave #(.AXI_ID_WIDTH(4), .MEM_ADDR_WIDTH(8)) dut (
        .clk(clk), .rstn(rst),
        .i_awaddr(awaddr), .i_awid(awid), .i_awlen(awlen), .i_awvalid(awvalid), .o_awready(o_awready),
        .i_wdata(wdata), .i_wid(wid), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(bready),
        .i_araddr(araddr), .i_arid(arid), .i_arlen(arlen), .i_arvalid(arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
        .i_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] id; logic last; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] mdl [256];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    int          n_chk = 0, n_fail = 0;

    logic [31:0] last_rdata = '0;
    logic        last_rlast = 1'b0;
    logic [3:0]  last_bid = '0;
    logic [1:0]  last_bresp = '0;
    logic        r_stall = 1'b0, b_stall = 1'b0;
    logic [36:0] r_sav = '0;
    logic [5:0]  b_sav = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall && o_rvalid) chk("r_hold", {o_rdata, o_rid, o_rlast}, r_sav);
            if (b_stall && o_bvalid) chk("b_hold", {o_bid, o_bresp}, b_sav);
            if (o_rvalid && rready) begin
                if (rq.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    r_exp_t e;
                    e = rq.pop_front();
                    chk("rdata", o_rdata, e.data);
                    chk("rid", o_rid, e.id);
                    chk("rlast", o_rlast, e.last);
                    chk("rresp", o_rresp, 0);
                end
                last_rdata = o_rdata;
                last_rlast = o_rlast;
            end
            if (o_bvalid && bready) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    b_exp_t e;
                    e = bq.pop_front();
                    chk("bid", o_bid, e.id);
                    chk("bresp", o_bresp, e.resp);
                end
                last_bid = o_bid;
                last_bresp = o_bresp;
            end
            r_stall = o_rvalid && !rready;
            r_sav   = {o_rdata, o_rid, o_rlast};
            b_stall = o_bvalid && !bready;
            b_sav   = {o_bid, o_bresp};
        end
    end

    // Write burst from wdat/wstb; bad_beat flips wlast on that beat (-1: none).
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input int bad_beat, input int bdelay, input bit gaps);
        logic [7:0] base;
        logic [7:0] w;
        bit         err;
        b_exp_t     be;
        int         t;
        base = addr[9:2];
        err  = 1'b0;
        for (int k = 0; k <= len; k++) begin
            w = base + 8'(k);
            for (int b = 0; b < 4; b++) if (wstb[k][b]) mdl[w][8*b +: 8] = wdat[k][8*b +: 8];
            if (k == bad_beat) err = 1'b1;
        end
        be.id = id;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
        be.resp = err ? 2'b10 : 2'b00;
`else
        be.resp = 2'b00;
`endif
        bq.push_back(be);
        @(posedge clk); #1;
        awaddr = addr; awid = id; awlen = 4'(len); awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_awready && t < 100);
        chk("aw_handshake", o_awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            wdata = wdat[k]; wstrb = wstb[k]; wid = 4'($urandom);
            wlast = (k == len) ^ (k == bad_beat);
            wvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!o_wready && t < 100);
            chk("w_handshake", o_wready, 1);
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
        end
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            chk("b_stall_bvalid", o_bvalid, 1);
            chk("b_stall_awready", o_awready, 0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_bvalid && t < 100);
        chk("b_handshake", o_bvalid, 1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len, input bit rnd_rdy);
        r_exp_t e;
        logic [7:0] w;
        int t, got;
        for (int k = 0; k <= len; k++) begin
            w = addr[9:2] + 8'(k);
            e.data = mdl[w]; e.id = id; e.last = (k == len);
            rq.push_back(e);
        end
        @(posedge clk); #1;
        araddr = addr; arid = id; arlen = 4'(len); arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_arready && t < 100);
        chk("ar_handshake", o_arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 0; t = 0;
        while (got <= len && t < 300) begin
            rready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (o_rvalid && rready) got++;
            t++;
            @(posedge clk); #1;
        end
        chk("r_beats", got, len + 1);
        rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", o_awready, 0);
        chk("rst_arready", o_arready, 0);
        chk("rst_wready", o_wready, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_ids_resp_last", {o_bid, o_rid, o_bresp, o_rresp, o_rlast}, 0);
        chk("rst_rdata", o_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready_low_before_edge", {o_awready, o_arready}, 2'b00);
        @(negedge clk);
        chk("rel_ready_high_after_edge", {o_awready, o_arready}, 2'b11);

        // Fill the whole memory so the model knows every word.
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
            do_write(32'(b * 64), 4'(b), 15, -1, 0, 1'b0);
        end

        // Single write / read.
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(32'h10, 4'd3, 0, -1, 0, 1'b0);
        chk("single_bid", last_bid, 3);
        chk("single_bresp", last_bresp, 0);
        do_read(32'h10, 4'd5, 0, 1'b0);
        chk("single_rdata", last_rdata, 32'hDEADBEEF);
        chk("single_rlast", last_rlast, 1);

        // Four-beat burst.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'(k + 1); wstb[k] = 4'hF; end
        do_write(32'h100, 4'd1, 3, -1, 0, 1'b0);
        do_read(32'h100, 4'd2, 3, 1'b0);
        chk("burst_last_data", last_rdata, 4);

        // Partial strobe.
        wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF;
        do_write(32'h20, 4'd0, 0, -1, 0, 1'b0);
        wdat[0] = 32'h12345678; wstb[0] = 4'h5;
        do_write(32'h20, 4'd0, 0, -1, 0, 1'b0);
        do_read(32'h20, 4'd0, 0, 1'b0);
        chk("strobe_rdata", last_rdata, 32'hFF34FF78);

        // Wrap at the memory end with B and R backpressure.
        wdat[0] = 32'hAAAA0001; wdat[1] = 32'hBBBB0002; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(32'h3FC, 4'd7, 1, -1, 5, 1'b0);
        do_read(32'h3FC, 4'd7, 1, 1'b1);
        do_read(32'h0, 4'd8, 0, 1'b0);
        chk("wrap_word0", last_rdata, 32'hBBBB0002);

        // Early wlast on beat 0 of a two-beat burst.
        wdat[0] = 32'h0000C0DE; wdat[1] = 32'h0000F00D; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(32'h40, 4'd9, 1, 0, 0, 1'b0);
`ifdef AXI_SLAVE_WLAST_CHECK_EN
        chk("early_wlast_bresp", last_bresp, 2'b10);
`else
        chk("early_wlast_bresp", last_bresp, 2'b00);
`endif
        do_read(32'h40, 4'd9, 1, 1'b0);

        // Reset in the middle of a read burst.
        begin
            r_exp_t e;
            for (int k = 0; k < 4; k++) begin
                e.data = mdl[8'h40 + 8'(k)]; e.id = 4'd4; e.last = (k == 3);
                rq.push_back(e);
            end
        end
        @(posedge clk); #1;
        araddr = 32'h100; arid = 4'd4; arlen = 4'd3; arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_arready && t < 100);
        chk("rst_test_ar", o_arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", o_rvalid, 0);
        chk("midrst_rdata", o_rdata, 0);
        chk("midrst_arready", o_arready, 0);
        rq.delete();
        rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_release_arready", o_arready, 1);
        do_read(32'h100, 4'd6, 3, 1'b1);
        chk("midrst_mem_intact", last_rdata, 4);

        // Randomized write/read pairs.
        for (int it = 0; it < 30; it++) begin
            int len, bad;
            len = $urandom_range(0, 15);
            for (int k = 0; k <= len; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
            bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            do_write($urandom, 4'($urandom), len, bad, $urandom_range(0, 3), 1'b1);
            do_read($urandom, 4'($urandom), $urandom_range(0, 15), 1'b1);
        end

        repeat (3) @(posedge clk);
        chk("bq_drained", bq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
